ps2_keycode_decoder: RTL and testbench

- Keyboard front end that produces the 8-bit game keycode consumed by the game control block.
- Receives PS/2 device-to-host frames: start bit, 8 data bits LSB-first, odd parity, stop bit.
- Tracks the E0 (extended) and F0 (break) prefixes and translates a fixed set of scan-code set 2 keys into game keycodes.
- Holds each game keycode for as long as the physical key is pressed.

---
 rtl/ps2_keycode_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_keycode_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder
// PS/2 keyboard front end: synchronises and filters the raw PS/2 lines,
// receives device-to-host frames, tracks the E0/F0 prefixes and turns a
// small set of scan-code set 2 keys into the game keycode, held for as
// long as the physical key stays pressed.
module ps2_keycode_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rxState_t;

    logic [1:0]    clkSync_q;
    logic [1:0]    datSync_q;
    logic          syncClk;
    logic          syncDat;

    logic          filtClk_q, filtClk_d;
    logic [FW-1:0] filtCnt_q, filtCnt_d;
    logic          filtPrev_q;
    logic          fallEdge;

    rxState_t      state_q, state_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] toCnt_q, toCnt_d;
    logic          byteValid_q, byteValid_d;
    logic          frameErr_q, frameErr_d;

    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [7:0]    keycode_q, keycode_d;
    logic          keyValid_q, keyValid_d;

    logic          mapHit;
    logic [7:0]    mapCode;

    assign syncClk = clkSync_q[1];
    assign syncDat = datSync_q[1];

    // Two-flop synchronisers for the asynchronous keyboard lines; idle-high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clkSync_q <= 2'b11;
            datSync_q <= 2'b11;
        end else begin
            clkSync_q <= {clkSync_q[0], PS2_CLK};
            datSync_q <= {datSync_q[0], PS2_DAT};
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN
    // consecutive samples at the new level; any bounce restarts the count.
    always_comb begin
        filtClk_d = filtClk_q;
        filtCnt_d = '0;
        if (syncClk != filtClk_q) begin
            if (filtCnt_q == FILT_LAST) begin
                filtClk_d = syncClk;
            end else begin
                filtCnt_d = filtCnt_q + 1'b1;
            end
        end
    end

    // Filter state plus the delayed copy used for falling-edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            filtClk_q  <= 1'b1;
            filtCnt_q  <= '0;
            filtPrev_q <= 1'b1;
        end else begin
            filtClk_q  <= filtClk_d;
            filtCnt_q  <= filtCnt_d;
            filtPrev_q <= filtClk_q;
        end
    end

    assign fallEdge = filtPrev_q & ~filtClk_q;

    // Receive FSM next state: steps only on filtered falling edges, and
    // abandons a frame whose clock stalls for TIMEOUT_CYCLES.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        toCnt_d     = '0;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;

        if (fallEdge) begin
            case (state_q)
                RX_IDLE: begin
                    if (!syncDat) begin
                        state_d  = RX_DATA;
                        bitCnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d[bitCnt_q] = syncDat;
                    bitCnt_d          = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    parity_d = syncDat;
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    if (syncDat && (^{shift_q, parity_q})) begin
                        byteValid_d = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end else if (state_q != RX_IDLE) begin
            if (toCnt_q == TO_LAST) begin
                frameErr_d = 1'b1;
                state_d    = RX_IDLE;
            end else begin
                toCnt_d = toCnt_q + 1'b1;
            end
        end
    end

    // Receive FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= RX_IDLE;
            bitCnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            toCnt_q     <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            toCnt_q     <= toCnt_d;
            byteValid_q <= byteValid_d;
            frameErr_q  <= frameErr_d;
        end
    end

    // Scan-code to game-keycode table; ext selects the E0-prefixed page.
    always_comb begin
        mapHit  = 1'b0;
        mapCode = 8'h00;
        case ({ext_q, shift_q})
            {1'b0, 8'h29}: begin mapHit = 1'b1; mapCode = 8'h20; end
            {1'b1, 8'h72}: begin mapHit = 1'b1; mapCode = 8'h26; end
            {1'b0, 8'h5A}: begin mapHit = 1'b1; mapCode = 8'h0D; end
            {1'b0, 8'h76}: begin mapHit = 1'b1; mapCode = 8'h0C; end
            default:       begin mapHit = 1'b0; mapCode = 8'h00; end
        endcase
    end

    // Byte decode: prefixes set flags, codes act on the held keycode. A break
    // only releases the keycode it names so overlapping presses survive.
    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        keycode_d  = keycode_q;
        keyValid_d = 1'b0;
        if (byteValid_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (mapHit) begin
                    if (!brk_q) begin
                        keycode_d  = mapCode;
                        keyValid_d = 1'b1;
                    end else if (keycode_q == mapCode) begin
                        keycode_d = 8'h00;
                    end
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // Decoder state and the registered keycode outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            keycode_q  <= 8'h00;
            keyValid_q <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            keycode_q  <= keycode_d;
            keyValid_q <= keyValid_d;
        end
    end

    assign keycode   = keycode_q;
    assign key_valid = keyValid_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// tb_ps2_keycode_decoder
// Directed bench: drives PS/2 frames into the decoder, keeps a queue of the
// pulses each step should produce and checks held keycode levels.
module tb_ps2_keycode_decoder;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF_BIT       = 15;

    logic       Clk;
    logic       Reset;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_err;

    int vecCount  = 0;
    int missCount = 0;

    // Expected pulses: {is_frame_err, keycode at a key_valid pulse}.
    logic [8:0] expQ[$];

    ps2_keycode_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .keycode   (keycode),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    // 10-unit system clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift the first n bits of an 11-bit frame (LSB = start bit) onto the lines.
    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = bits[i];
            tick(HALF_BIT);
            PS2_CLK = 1'b0;
            tick(HALF_BIT);
            PS2_CLK = 1'b1;
        end
        tick(HALF_BIT);
        PS2_DAT = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic badParity);
        logic par;
        par = (~^data) ^ badParity;
        sendBits({1'b1, par, data, 1'b0}, 11);
        tick(20);
    endtask

    // Pulse scoreboard: every key_valid/frame_err pulse must match the queue head.
    always @(negedge Clk) begin
        logic [8:0] obs;
        logic [8:0] exp;
        if (!Reset && (key_valid || frame_err)) begin
            obs = {frame_err, frame_err ? 8'h00 : keycode};
            exp = (expQ.size() > 0) ? expQ.pop_front() : 9'h1FF;
            vecCount++;
            assert (obs === exp) else begin
                missCount++;
                $error("[TB] FAIL pulse: observed %h expected %h", obs, exp);
            end
            vecCount++;
            assert (!(key_valid && frame_err)) else begin
                missCount++;
                $error("[TB] FAIL pulse_overlap: observed 1 expected 0");
            end
        end
    end

    initial begin
        Reset   = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        tick(5);
        checkOutput("reset_keycode", {1'b0, keycode}, 9'h000);
        checkOutput("reset_valid", {8'h00, key_valid}, 9'h000);
        checkOutput("reset_err", {8'h00, frame_err}, 9'h000);
        Reset = 1'b0;
        tick(5);

        // Space press and release.
        expQ.push_back({1'b0, 8'h20});
        applyStimulus(8'h29, 1'b0);
        checkOutput("space_make", {1'b0, keycode}, {1'b0, 8'h20});
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h29, 1'b0);
        checkOutput("space_break", {1'b0, keycode}, 9'h000);

        // Extended down arrow, bare 72 ignored, then released.
        expQ.push_back({1'b0, 8'h26});
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'h72, 1'b0);
        checkOutput("down_make", {1'b0, keycode}, {1'b0, 8'h26});
        applyStimulus(8'h72, 1'b0);
        checkOutput("bare_72", {1'b0, keycode}, {1'b0, 8'h26});
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h72, 1'b0);
        checkOutput("down_break", {1'b0, keycode}, 9'h000);

        // Overlapping presses: releasing the older key keeps the newer one.
        expQ.push_back({1'b0, 8'h20});
        applyStimulus(8'h29, 1'b0);
        checkOutput("ovl_space", {1'b0, keycode}, {1'b0, 8'h20});
        expQ.push_back({1'b0, 8'h0D});
        applyStimulus(8'h5A, 1'b0);
        checkOutput("ovl_enter", {1'b0, keycode}, {1'b0, 8'h0D});
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h29, 1'b0);
        checkOutput("ovl_space_brk", {1'b0, keycode}, {1'b0, 8'h0D});
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h5A, 1'b0);
        checkOutput("ovl_enter_brk", {1'b0, keycode}, 9'h000);

        // Escape press as a further mapped code.
        expQ.push_back({1'b0, 8'h0C});
        applyStimulus(8'h76, 1'b0);
        checkOutput("esc_make", {1'b0, keycode}, {1'b0, 8'h0C});
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h76, 1'b0);
        checkOutput("esc_break", {1'b0, keycode}, 9'h000);

        // Parity error drops the byte; the good repeat is accepted.
        expQ.push_back({1'b1, 8'h00});
        applyStimulus(8'h29, 1'b1);
        checkOutput("parity_drop", {1'b0, keycode}, 9'h000);
        expQ.push_back({1'b0, 8'h20});
        applyStimulus(8'h29, 1'b0);
        checkOutput("parity_recover", {1'b0, keycode}, {1'b0, 8'h20});

        // Timeout after start plus four data bits.
        expQ.push_back({1'b1, 8'h00});
        sendBits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
        tick(TIMEOUT_CYCLES + 10);
        checkOutput("timeout_hold", {1'b0, keycode}, {1'b0, 8'h20});
        expQ.push_back({1'b0, 8'h0D});
        applyStimulus(8'h5A, 1'b0);
        checkOutput("timeout_recover", {1'b0, keycode}, {1'b0, 8'h0D});

        // Reset mid-frame while space is held.
        expQ.push_back({1'b0, 8'h20});
        applyStimulus(8'h29, 1'b0);
        checkOutput("pre_reset", {1'b0, keycode}, {1'b0, 8'h20});
        sendBits({1'b1, 1'b0, 8'h29, 1'b0}, 3);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        tick(2);
        checkOutput("mid_reset", {1'b0, keycode}, 9'h000);
        tick(TIMEOUT_CYCLES + 10);
        checkOutput("post_reset_quiet", {1'b0, keycode}, 9'h000);

        // Short clock glitch with data low must not start a frame.
        PS2_DAT = 1'b0;
        tick(3);
        PS2_CLK = 1'b0;
        tick(2);
        PS2_CLK = 1'b1;
        tick(3);
        PS2_DAT = 1'b1;
        tick(TIMEOUT_CYCLES + 10);
        checkOutput("glitch_quiet", {1'b0, keycode}, 9'h000);
        expQ.push_back({1'b0, 8'h0D});
        applyStimulus(8'h5A, 1'b0);
        checkOutput("glitch_next", {1'b0, keycode}, {1'b0, 8'h0D});

        tick(10);
        checkOutput("queue_drained", 9'(expQ.size()), 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
